// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-ported integer register file.
//
// NRD combinational read ports and NWR write ports over an NREG x XLEN array.
// Optional same-cycle write-to-read bypass and optional hardwired-zero register 0.
// When several writes in one cycle target the same register, the highest-indexed
// write port wins. A counter-driven sequencer clears one entry per cycle after
// reset or after a run-time clear_req. While it runs, writes are ignored and
// reads return zero.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset (restarts the clear sequence)
//   clear_req     one-cycle request to re-run the clear sequence
//   ready         high once the array is cleared and normal operation is running
//   rd_addr       NRD packed read addresses, port p at [p*AW +: AW]
//   rd_data       NRD packed read data, port p at [p*XLEN +: XLEN] (combinational)
//   wr_en         per-port write enables
//   wr_addr       NWR packed write addresses
//   wr_data       NWR packed write data
//   wr_collision  registered pulse: two or more effective writes hit one address
//                 in the previous cycle
module regfile_mp #(
  parameter  int XLEN      = 32,
  parameter  int NREG      = 32,
  parameter  int NRD       = 2,
  parameter  int NWR       = 2,
  parameter  int BYPASS    = 1,
  parameter  int ZERO_REG0 = 1,
  localparam int AW        = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear_req,
  output logic                 ready,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  output logic                 wr_collision
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  state_t          state_q, state_d;
  logic [AW-1:0]   clear_cnt_q, clear_cnt_d;
  logic            ready_q, ready_d;
  logic            coll_q, coll_d;
  logic            clr_we;

  logic [XLEN-1:0] regs_q [NREG];

  logic [AW-1:0]   waddr [NWR];
  logic [XLEN-1:0] wdata [NWR];
  logic [NWR-1:0]  we;
  logic            dup;

  logic [AW-1:0]   raddr [NRD];
  logic [XLEN-1:0] rval  [NRD];

  // Unpack write ports; a write only lands in RUN, with no clear or reset
  // pending, and never on register 0 when it is hardwired.
  always_comb begin
    for (int w = 0; w < NWR; w++) begin
      waddr[w] = wr_addr[w*AW +: AW];
      wdata[w] = wr_data[w*XLEN +: XLEN];
      we[w]    = wr_en[w] && !((ZERO_REG0 != 0) && (waddr[w] == '0))
                 && (state_q == ST_RUN) && !clear_req && !reset;
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NWR; i++) begin
      for (int j = i + 1; j < NWR; j++) begin
        if (we[i] && we[j] && (waddr[i] == waddr[j])) dup = 1'b1;
      end
    end
  end

  // Sequencer next state
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    coll_d      = 1'b0;
    clr_we      = 1'b0;
    case (state_q)
      ST_INIT: begin
        if (clear_req) begin
          clear_cnt_d = '0;
        end else begin
          clr_we = 1'b1;
          if (clear_cnt_q == LAST) begin
            state_d     = ST_RUN;
            clear_cnt_d = '0;
          end else begin
            clear_cnt_d = clear_cnt_q + AW'(1);
          end
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          state_d     = ST_INIT;
          clear_cnt_d = '0;
        end else begin
          coll_d = dup;
        end
      end
      default: state_d = ST_INIT;
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      clear_cnt_q <= '0;
      ready_q     <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
      ready_q     <= ready_d;
      coll_q      <= coll_d;
    end
  end

  // Storage: no reset; the sequencer owns clearing. Later ports overwrite
  // earlier ones in the loop, giving highest-index priority.
  always_ff @(posedge clk) begin
    if (clr_we) regs_q[clear_cnt_q] <= '0;
    for (int w = 0; w < NWR; w++) begin
      if (we[w]) regs_q[waddr[w]] <= wdata[w];
    end
  end

  // Read ports: array, then bypass (highest port last), then zero overrides.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      raddr[p] = rd_addr[p*AW +: AW];
      rval[p]  = regs_q[raddr[p]];
      if (BYPASS != 0) begin
        for (int w = 0; w < NWR; w++) begin
          if (we[w] && (waddr[w] == raddr[p])) rval[p] = wdata[w];
        end
      end
      if ((ZERO_REG0 != 0) && (raddr[p] == '0)) rval[p] = '0;
      if (state_q != ST_RUN) rval[p] = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int p = 0; p < NRD; p++) rd_data[p*XLEN +: XLEN] = rval[p];
  end

  assign ready        = ready_q;
  assign wr_collision = coll_q;

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic                reset, clear_req;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                ready_a, ready_b, coll_a, coll_b;
  logic [NRD*XLEN-1:0] rd_a, rd_b;

  // a: bypass on, reg0 hardwired zero.  b: bypass off, reg0 writable.
  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG0(1)) dut_a (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
    .rd_addr(rd_addr), .rd_data(rd_a), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_collision(coll_a));

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG0(0)) dut_b (
    .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
    .rd_addr(rd_addr), .rd_data(rd_b), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_collision(coll_b));

  typedef struct packed {
    logic                rdy;
    logic [1:0]          coll;
    logic [NRD*XLEN-1:0] rd0;
    logic [NRD*XLEN-1:0] rd1;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Reference model: config 0 = (bypass, zero reg0), config 1 = (no bypass, writable reg0)
  logic [XLEN-1:0] mem [2][NREG];
  int  init_left;
  bit  m_ready;
  bit  m_coll [2];

  function automatic bit eff(int c, int w);
    logic [AW-1:0] a;
    a = wr_addr[w*AW +: AW];
    return wr_en[w] && !((c == 0) && (a == 0));
  endfunction

  function automatic logic [XLEN-1:0] exp_read(int c, logic [AW-1:0] a);
    if (!m_ready) return '0;
    if ((c == 0) && (a == 0)) return '0;
    if ((c == 0) && !reset && !clear_req) begin
      for (int w = NWR - 1; w >= 0; w--) begin
        if (eff(c, w) && (wr_addr[w*AW +: AW] == a)) return wr_data[w*XLEN +: XLEN];
      end
    end
    return mem[c][a];
  endfunction

  task automatic model_edge();
    if (reset) begin
      init_left = NREG; m_ready = 0; m_coll[0] = 0; m_coll[1] = 0;
    end else if (m_ready) begin
      if (clear_req) begin
        m_ready = 0; init_left = NREG; m_coll[0] = 0; m_coll[1] = 0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          m_coll[c] = 0;
          for (int i = 0; i < NWR; i++)
            for (int j = i + 1; j < NWR; j++)
              if (eff(c, i) && eff(c, j) && (wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]))
                m_coll[c] = 1;
          for (int w = 0; w < NWR; w++)
            if (eff(c, w)) mem[c][wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
        end
      end
    end else begin
      m_coll[0] = 0; m_coll[1] = 0;
      if (clear_req) init_left = NREG;
      else begin
        init_left--;
        if (init_left == 0) begin
          m_ready = 1;
          for (int c = 0; c < 2; c++)
            for (int r = 0; r < NREG; r++) mem[c][r] = '0;
        end
      end
    end
  endtask

  // One clock cycle: record expected outputs for the current inputs, then advance.
  task automatic cyc();
    exp_t e;
    e.rdy  = m_ready;
    e.coll = {m_coll[1], m_coll[0]};
    for (int p = 0; p < NRD; p++) begin
      e.rd0[p*XLEN +: XLEN] = exp_read(0, rd_addr[p*AW +: AW]);
      e.rd1[p*XLEN +: XLEN] = exp_read(1, rd_addr[p*AW +: AW]);
    end
    sb.push_back(e);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_wr(int w, bit en, logic [AW-1:0] a, logic [XLEN-1:0] d);
    wr_en[w] = en;
    wr_addr[w*AW +: AW] = a;
    wr_data[w*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(int p, logic [AW-1:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
  endtask

  // Monitor: compares DUT outputs against queued expectations mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ready_a", 64'(ready_a), 64'(e.rdy));
        chk("ready_b", 64'(ready_b), 64'(e.rdy));
        chk("coll_a",  64'(coll_a),  64'(e.coll[0]));
        chk("coll_b",  64'(coll_b),  64'(e.coll[1]));
        chk("rd_a",    64'(rd_a),    64'(e.rd0));
        chk("rd_b",    64'(rd_b),    64'(e.rd1));
      end
    end
  end

  initial begin
    reset = 1; clear_req = 0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    @(posedge clk); #1;
    init_left = NREG; m_ready = 0; m_coll[0] = 0; m_coll[1] = 0;
    cyc();
    reset = 0;

    // INIT: writes ignored, reads zero, ready after NREG edges
    set_wr(0, 1, 5, 32'hDEADBEEF); set_rd(0, 5); set_rd(1, 0);
    repeat (NREG) cyc();
    wr_en = '0;
    cyc();

    // Bypass vs. registered read-after-write
    set_wr(0, 1, 7, 32'h12345678); set_rd(0, 3); set_rd(1, 7);
    cyc();
    wr_en = '0;
    cyc();

    // Same-address priority and collision pulse
    set_wr(0, 1, 3, 32'hAAAA0000); set_wr(1, 1, 3, 32'h5555FFFF); set_rd(0, 3);
    cyc();
    wr_en = '0;
    cyc(); cyc();

    // Register 0 handling
    set_wr(0, 1, 0, 32'hFFFFFFFF); set_wr(1, 1, 0, 32'hFFFFFFFF); set_rd(0, 0); set_rd(1, 0);
    cyc();
    wr_en = '0;
    cyc(); cyc();

    // Fill, then clear with a dropped write
    for (int i = 1; i < NREG; i++) begin
      set_wr(i % 2, 1, AW'(i), 32'(i)); wr_en[1 - (i % 2)] = 0;
      cyc();
    end
    wr_en = '0;
    for (int i = 0; i < NREG; i += 2) begin set_rd(0, AW'(i)); set_rd(1, AW'(i + 1)); cyc(); end
    clear_req = 1; set_wr(0, 1, 2, 32'h99); set_rd(0, 2);
    cyc();
    clear_req = 0; wr_en = '0;
    repeat (NREG) cyc();
    for (int i = 0; i < NREG; i += 2) begin set_rd(0, AW'(i)); set_rd(1, AW'(i + 1)); cyc(); end

    // Reset in the middle of INIT
    clear_req = 1; cyc(); clear_req = 0;
    repeat (10) cyc();
    reset = 1; cyc(); reset = 0;
    repeat (NREG + 2) cyc();

    // Randomised traffic
    repeat (1500) begin
      reset     = ($urandom_range(0, 299) == 0);
      clear_req = ($urandom_range(0, 99) == 0);
      for (int w = 0; w < NWR; w++)
        set_wr(w, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG - 1)),
               $urandom);
      for (int p = 0; p < NRD; p++)
        set_rd(p, ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NREG - 1)));
      cyc();
    end
    reset = 0; clear_req = 0; wr_en = '0;

    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-ported integer register file, the next-generation replacement for the fixed 2-read/1-write 32×32 file in the core. It provides NRD combinational read ports and NWR write ports, with optional write-to-read bypass and deterministic same-address write priority. A counter-driven initialisation sequencer clears the array one entry per cycle, which keeps the storage LUTRAM-friendly. The same sequencer can be re-triggered at run time through `clear_req`. The block sits between decode (reads) and writeback (writes) of a multi-issue pipeline.

## Interface
- XLEN, 32, register width in bits
- NREG, 32, number of registers (power of two, ≥2); AW = $clog2(NREG) is a localparam
- NRD, 2, number of read ports (≥1)
- NWR, 2, number of write ports (≥1)
- BYPASS, 1, 1 = a same-cycle write is visible on matching read ports; 0 = reads return stored array contents only
- ZERO_REG0, 1, 1 = register 0 is hardwired to zero
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- clear_req  input  1  one-cycle request to re-run the clear sequence
- ready  output  1  high when the file accepts writes and returns valid reads
- rd_addr  input  NRD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_data  output  NRD*XLEN  read data; port p uses bits [p*XLEN +: XLEN]
- wr_en  input  NWR  per-port write enable
- wr_addr  input  NWR*AW  write addresses, packed the same way as rd_addr
- wr_data  input  NWR*XLEN  write data, packed the same way as rd_data
- wr_collision  output  1  registered pulse: two or more enabled write ports targeted the same effective address in the previous cycle

## Operation
- States:
  - INIT: clear_cnt walks 0..NREG-1 and writes 0 to entry clear_cnt, one entry per cycle.
  - RUN: normal operation.
- Reset: state←INIT, clear_cnt←0, ready←0, wr_collision←0. Array contents are not reset directly; the sequencer clears them.
- INIT, each cycle:
  - clear entry clear_cnt, then clear_cnt←clear_cnt+1.
  - When clear_cnt==NREG-1: state←RUN and ready←1, registered at that same edge.
- INIT behaviour:
  - All wr_en are ignored.
  - All rd_data are forced to 0.
  - wr_collision stays 0.
- RUN + clear_req: state←INIT, clear_cnt←0, ready←0. All writes in that cycle are dropped.
- INIT + clear_req: clear_cnt restarts at 0.
- Effective write: wr_en[w]=1, and not (ZERO_REG0 and wr_addr[w]==0).
- Write priority: if several effective writes target the same address, the highest-indexed port wins. The others are discarded.
- wr_collision: a registered flag, set in the next cycle if any two effective writes in RUN share an address, otherwise cleared.
- Read port p, combinational, evaluated in this order:
  - ZERO_REG0 and rd_addr==0 → 0.
  - BYPASS=1 and any effective write matches rd_addr → wr_data of the highest-indexed matching port.
  - Otherwise → registers[rd_addr].
- All arithmetic is on AW-bit addresses. clear_cnt is AW bits and never wraps past NREG-1 within INIT.

## Timing
- Write latency: data is stored at the rising edge at the end of the cycle in which wr_en is sampled.
- Read after write:
  - BYPASS=0: the new value is visible in the cycle after the edge.
  - BYPASS=1: the new value is visible in the same cycle.
- Read latency: zero cycles, combinational from rd_addr.
- Init latency: ready rises at the NREG-th rising edge after the first edge with reset=0. The same applies after clear_req: NREG edges counted from the edge that samples it.
- Reset asserted mid-INIT or mid-RUN: takes effect at the next edge and restarts the sequence from clear_cnt=0.
- reset has priority over clear_req; clear_req has priority over writes.

## Test plan
- Reset, then reset=0 with NREG=32 → ready=0 for 32 edges, ready=1 after edge 32. rd_data=0 on all ports throughout INIT. A write of 0xDEADBEEF to reg 5 during INIT is not stored: reg 5 reads 0 once in RUN.
- RUN, write port 0 writes reg 7=0x12345678 → BYPASS=1: read port 1 at addr 7 returns 0x12345678 in the same cycle. BYPASS=0: the same read returns 0 in that cycle and 0x12345678 in the next cycle.
- Both write ports target reg 3, port0=0xAAAA0000 and port1=0x5555FFFF → reg 3 holds 0x5555FFFF. wr_collision=1 for exactly one cycle after the write.
- With ZERO_REG0=1, write 0xFFFFFFFF to reg 0 on both ports → reads of reg 0 return 0 (bypass included) and wr_collision stays 0. With ZERO_REG0=0, reg 0 reads 0xFFFFFFFF.
- Fill regs 1..31 with their own index. Pulse clear_req together with a write of 0x99 to reg 2 → the write is dropped, ready=0 for 32 edges, then every register reads 0.
- Assert reset at clear_cnt=10 of INIT → ready stays 0 and the count restarts. ready rises 32 edges after reset deasserts.
